// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared state encoding and constants for the OV7670 init sequencer
package ov7670_pkg;

    typedef enum logic [2:0] {
        PWRUP,
        FETCH,
        LOAD,
        CALL,
        POST,
        RSTWAIT,
        DONE
    } seqState_t;

    localparam logic [15:0] COM7_SWRESET = 16'h1280;
    localparam logic [7:0]  SCCB_DEV_WR  = 8'h42;

    localparam logic [23:0] POWERUP_CYCLES_DEF    = 24'd2_000_000;
    localparam logic [23:0] RESET_WAIT_CYCLES_DEF = 24'd1_000_000;
    localparam logic [7:0]  LUT_SIZE_DEF          = 8'd166;

endpackage

// File: rtl/ov7670_reg_rom.sv
// rtl/ov7670_reg_rom.sv - registered {reg_addr, reg_data} table for OV7670 bring-up
module ov7670_reg_rom
    import ov7670_pkg::*;
#(
    parameter logic [7:0] LUT_SIZE = LUT_SIZE_DEF
) (
    input  logic        clk,
    input  logic [7:0]  addr,
    output logic [15:0] data
);

    logic [15:0] entry;

    // Unpopulated slots and anything past LUT_SIZE read as the 16'hFFFF marker.
    always_comb begin
        entry = 16'hFFFF;
        case (addr)
            8'd0:  entry = COM7_SWRESET;
            8'd1:  entry = 16'h1204;
            8'd2:  entry = 16'h3A04;
            8'd3:  entry = 16'h1100;
            8'd4:  entry = 16'h0C00;
            8'd5:  entry = 16'h3E00;
            8'd6:  entry = 16'h8C00;
            8'd7:  entry = 16'h0400;
            8'd8:  entry = 16'h40D0;
            8'd9:  entry = 16'h1438;
            8'd10: entry = 16'h4FB3;
            8'd11: entry = 16'h50B3;
            8'd12: entry = 16'h5100;
            8'd13: entry = 16'h523D;
            8'd14: entry = 16'h53A7;
            8'd15: entry = 16'h54E4;
            8'd16: entry = 16'h589E;
            8'd17: entry = 16'h3DC0;
            8'd18: entry = 16'h1714;
            8'd19: entry = 16'h1802;
            8'd20: entry = 16'h3280;
            8'd21: entry = 16'h1903;
            8'd22: entry = 16'h1A7B;
            8'd23: entry = 16'h030A;
            8'd24: entry = 16'h0E61;
            8'd25: entry = 16'h0F4B;
            8'd26: entry = 16'h1602;
            8'd27: entry = 16'h1E07;
            8'd28: entry = 16'h2102;
            8'd29: entry = 16'h2291;
            8'd30: entry = 16'h2907;
            8'd31: entry = 16'h330B;
            8'd32: entry = 16'h350B;
            8'd33: entry = 16'h371D;
            8'd34: entry = 16'h3871;
            8'd35: entry = 16'h392A;
            8'd36: entry = 16'h3C78;
            8'd37: entry = 16'h4D40;
            8'd38: entry = 16'h4E20;
            8'd39: entry = 16'h6900;
            8'd40: entry = 16'h6B4A;
            8'd41: entry = 16'h7410;
            8'd42: entry = 16'hB084;
            8'd43: entry = 16'hB10C;
            8'd44: entry = 16'hB20E;
            8'd45: entry = 16'hB382;
            8'd46: entry = 16'hB80A;
            default: entry = 16'hFFFF;
        endcase
    end

    always_ff @(posedge clk) begin
        data <= (addr < LUT_SIZE) ? entry : 16'hFFFF;
    end

endmodule

// File: rtl/ov7670_init_seq.sv
// rtl/ov7670_init_seq.sv - walks the OV7670 register table into the SCCB engine; OV7670_SWRESET_WAIT_EN adds a settle wait after COM7 reset
module ov7670_init_seq
    import ov7670_pkg::*;
#(
    parameter logic [23:0] POWERUP_CYCLES    = POWERUP_CYCLES_DEF,
    parameter logic [23:0] RESET_WAIT_CYCLES = RESET_WAIT_CYCLES_DEF,
    parameter logic [7:0]  LUT_SIZE          = LUT_SIZE_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iStart,
    input  logic        iDone,
    output logic        oCall,
    output logic [15:0] oData,
    output logic        oBusy,
    output logic        oInitDone,
    output logic [7:0]  oIndex
);

    localparam logic [7:0] LAST_INDEX = LUT_SIZE - 8'd1;

    seqState_t   state;
    logic [23:0] cnt;
    logic [15:0] romData;

    ov7670_reg_rom #(
        .LUT_SIZE(LUT_SIZE)
    ) uRom (
        .clk (clk),
        .addr(oIndex),
        .data(romData)
    );

`ifndef OV7670_SWRESET_WAIT_EN
    logic unusedResetWait;
    assign unusedResetWait = ^RESET_WAIT_CYCLES;
`endif

    // cnt is only non-zero inside PWRUP/RSTWAIT and is zeroed on leaving them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= PWRUP;
            cnt       <= '0;
            oCall     <= 1'b0;
            oData     <= '0;
            oBusy     <= 1'b1;
            oInitDone <= 1'b0;
            oIndex    <= '0;
        end else begin
            case (state)
                PWRUP: begin
                    if (cnt == POWERUP_CYCLES - 24'd1) begin
                        cnt   <= '0;
                        state <= FETCH;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    oData <= romData;
                    oCall <= 1'b1;
                    state <= CALL;
                end
                CALL: begin
                    if (iDone) begin
                        oCall <= 1'b0;
                        state <= POST;
                    end
                end
                POST: begin
                    if (oIndex == LAST_INDEX) begin
                        oBusy     <= 1'b0;
                        oInitDone <= 1'b1;
                        state     <= DONE;
                    end
`ifdef OV7670_SWRESET_WAIT_EN
                    else if (oData == COM7_SWRESET) begin
                        cnt   <= '0;
                        state <= RSTWAIT;
                    end
`endif
                    else begin
                        oIndex <= oIndex + 8'd1;
                        state  <= FETCH;
                    end
                end
`ifdef OV7670_SWRESET_WAIT_EN
                RSTWAIT: begin
                    if (cnt == RESET_WAIT_CYCLES - 24'd1) begin
                        cnt    <= '0;
                        oIndex <= oIndex + 8'd1;
                        state  <= FETCH;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
`endif
                DONE: begin
                    if (iStart) begin
                        oIndex    <= '0;
                        oBusy     <= 1'b1;
                        oInitDone <= 1'b0;
                        state     <= FETCH;
                    end
                end
                default: begin
                    cnt   <= '0;
                    oCall <= 1'b0;
                    state <= PWRUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_init_seq.sv
// tb/tb_ov7670_init_seq.sv - self-checking bench for ov7670_init_seq (honours OV7670_SWRESET_WAIT_EN)
module tb_ov7670_init_seq;
    import ov7670_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        iStart;
    logic        iDone;
    logic        oCall;
    logic [15:0] oData;
    logic        oBusy;
    logic        oInitDone;
    logic [7:0]  oIndex;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  idx;
        int          gap;
    } vec_t;

    vec_t        vec [3];
    logic [15:0] expQ [$];

    ov7670_init_seq #(
        .POWERUP_CYCLES   (24'd10),
        .RESET_WAIT_CYCLES(24'd20),
        .LUT_SIZE         (8'd3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .iStart   (iStart),
        .iDone    (iDone),
        .oCall    (oCall),
        .oData    (oData),
        .oBusy    (oBusy),
        .oInitDone(oInitDone),
        .oIndex   (oIndex)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pushAll();
        for (int i = 0; i < 3; i++) expQ.push_back(vec[i].data);
    endtask

    // Count ticks until oCall is seen high, bounded so a dead DUT still reaches the summary.
    task automatic waitCall(input int start, output int n);
        n = start;
        while (oCall !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
    endtask

    // SCCB engine model: hold the request ~50 cycles, then pulse iDone once.
    task automatic serveWrite(input int i);
        logic [15:0] exp;
        logic [15:0] held;
        logic        stable;
        exp = (expQ.size() > 0) ? expQ.pop_front() : 16'hxxxx;
        check("write_data", {16'h0, oData}, {16'h0, exp});
        check("write_index", {24'h0, oIndex}, {24'h0, vec[i].idx});
        held   = oData;
        stable = 1'b1;
        for (int k = 0; k < 48; k++) begin
            tick();
            if (oCall !== 1'b1 || oData !== held) stable = 1'b0;
        end
        check("call_hold_stable", {31'h0, stable}, 32'h1);
        iDone = 1'b1;
        tick();
        iDone = 1'b0;
        check("call_fall", {31'h0, oCall}, 32'h0);
    endtask

    task automatic runTable();
        int n;
        for (int i = 0; i < 3; i++) begin
            serveWrite(i);
            if (i < 2) begin
                waitCall(0, n);
                check("call_gap", n, vec[i + 1].gap);
            end
        end
        check("init_done_t1", {31'h0, oInitDone}, 32'h0);
        tick();
        check("init_done_t2", {31'h0, oInitDone}, 32'h1);
        check("busy_done", {31'h0, oBusy}, 32'h0);
        check("index_done", {24'h0, oIndex}, 32'h2);
        check("scoreboard_empty", expQ.size(), 32'h0);
    endtask

    initial begin
        int n;
        vec[0] = '{data: 16'h1280, idx: 8'd0, gap: 0};
`ifdef OV7670_SWRESET_WAIT_EN
        vec[1] = '{data: 16'h1204, idx: 8'd1, gap: 23};
`else
        vec[1] = '{data: 16'h1204, idx: 8'd1, gap: 3};
`endif
        vec[2] = '{data: 16'h3A04, idx: 8'd2, gap: 3};

        rst    = 1'b1;
        iStart = 1'b0;
        iDone  = 1'b0;
        repeat (3) tick();
        check("rst_call", {31'h0, oCall}, 32'h0);
        check("rst_data", {16'h0, oData}, 32'h0);
        check("rst_busy", {31'h0, oBusy}, 32'h1);
        check("rst_initdone", {31'h0, oInitDone}, 32'h0);
        check("rst_index", {24'h0, oIndex}, 32'h0);

        // Power-up with spurious iDone in PWRUP (tick 4) and FETCH (tick 11).
        rst = 1'b0;
        n   = 0;
        while (oCall !== 1'b1 && n < 1000) begin
            iDone = (n == 3 || n == 10);
            tick();
            n++;
        end
        iDone = 1'b0;
        check("powerup_rise", n, 12);
        check("powerup_busy", {31'h0, oBusy}, 32'h1);
        pushAll();
        runTable();

        repeat (5) tick();
        check("done_idle_call", {31'h0, oCall}, 32'h0);
        check("done_idle_flag", {31'h0, oInitDone}, 32'h1);

        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        waitCall(1, n);
        check("restart_rise", n, 3);
        check("restart_busy", {31'h0, oBusy}, 32'h1);
        pushAll();

        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        check("start_in_call", {31'h0, oCall}, 32'h1);
        check("start_in_call_idx", {24'h0, oIndex}, 32'h0);
        serveWrite(0);
        waitCall(0, n);
        check("restart_gap", n, vec[1].gap);
        check("call_on_index1", {24'h0, oIndex}, 32'h1);

        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_call", {31'h0, oCall}, 32'h0);
        check("midrst_index", {24'h0, oIndex}, 32'h0);
        check("midrst_data", {16'h0, oData}, 32'h0);
        check("midrst_busy", {31'h0, oBusy}, 32'h1);
        waitCall(0, n);
        check("midrst_rise", n, 12);
        expQ.delete();
        pushAll();
        runTable();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
